pin_check_multi: RTL and testbench

- Parametrised successor to the team's PIN-entry checker.
- Collects PIN_LEN digits of DIGIT_W bits, one per rising edge of `submit`, and compares them against PASSKEY.
- Shows the result on LED-level outputs for a programmable hold time.
- Counts consecutive failures and enters a timed lockout after MAX_TRIES of them.
- Sits between the debounced keypad/switch front end and the board LEDs / downstream approval logic.

---
 rtl/pin_check_multi.sv | 191 +++++++++++++++++++
 tb/tb_pin_check_multi.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_check_multi.sv
// PIN-entry checker: gathers PIN_LEN digits on submit rising edges, compares them with
// PASSKEY, holds the verdict on LED outputs and locks out after MAX_TRIES straight failures.
module pin_check_multi #(
    parameter int                         DIGIT_W     = 2,
    parameter int                         PIN_LEN     = 4,
    parameter logic [DIGIT_W*PIN_LEN-1:0] PASSKEY     = 8'hA5,
    parameter int                         MAX_TRIES   = 3,
    parameter int                         HOLD_CYCLES = 25000000,
    parameter int                         LOCK_CYCLES = 250000000
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             submit,
    input  logic                             clear,
    output logic                             waiting,
    output logic                             correct,
    output logic                             incorrect,
    output logic                             approved,
    output logic                             locked,
    output logic [$clog2(PIN_LEN+1)-1:0]     digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
    output logic                             bug
);

    localparam int W       = DIGIT_W * PIN_LEN;
    localparam int CNT_W   = $clog2(PIN_LEN + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LD   = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PIN_LEN - 1);
    localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);
    localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTRY  = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_OK     = 3'd3;
    localparam logic [2:0] S_BAD    = 3'd4;
    localparam logic [2:0] S_LOCK   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     pin_q, pin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TRY_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             submit_q;
    logic             bug_q, bug_d;
    logic             waiting_q, waiting_d;
    logic             correct_q, correct_d;
    logic             incorrect_q, incorrect_d;
    logic             approved_q, approved_d;
    logic             locked_q, locked_d;
    logic [TRY_W-1:0] tries_q, tries_d;

    logic             sub_rise;
    logic [W-1:0]     pin_shift;

    assign sub_rise = submit & ~submit_q;

    // A single-digit PIN has no older digits to keep, so the shift degenerates to a load.
    generate
        if (PIN_LEN == 1) begin : g_single
            assign pin_shift = digit;
        end else begin : g_multi
            assign pin_shift = {pin_q[W-DIGIT_W-1:0], digit};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        pin_d      = pin_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        tmr_d      = tmr_q;
        bug_d      = bug_q;
        approved_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                pin_d = '0;
                cnt_d = '0;
                if (!clear && sub_rise) begin
                    pin_d   = W'(digit);
                    cnt_d   = CNT_W'(1);
                    state_d = (PIN_LEN == 1) ? S_VERIFY : S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (clear) begin
                    pin_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (sub_rise) begin
                    pin_d = pin_shift;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                if (pin_q == PASSKEY) begin
                    fail_d     = '0;
                    tmr_d      = HOLD_LD;
                    approved_d = 1'b1;
                    state_d    = S_OK;
                end else if (fail_q == LAST_TRY) begin
                    fail_d  = TRIES_MAX;
                    tmr_d   = LOCK_LD;
                    state_d = S_LOCK;
                end else begin
                    fail_d  = fail_q + TRY_W'(1);
                    tmr_d   = HOLD_LD;
                    state_d = S_BAD;
                end
            end
            S_OK, S_BAD, S_LOCK: begin
                if (tmr_q == '0) begin
                    pin_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (state_q == S_LOCK) begin
                        fail_d = '0;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                bug_d   = 1'b1;
                pin_d   = '0;
                cnt_d   = '0;
                tmr_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they flip on the same edge as the FSM.
        waiting_d   = (state_d == S_IDLE) || (state_d == S_ENTRY);
        correct_d   = (state_d == S_OK);
        incorrect_d = (state_d == S_BAD) || (state_d == S_LOCK);
        locked_d    = (state_d == S_LOCK);
        tries_d     = TRIES_MAX - fail_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pin_q       <= '0;
            cnt_q       <= '0;
            fail_q      <= '0;
            tmr_q       <= '0;
            submit_q    <= 1'b0;
            bug_q       <= 1'b0;
            waiting_q   <= 1'b1;
            correct_q   <= 1'b0;
            incorrect_q <= 1'b0;
            approved_q  <= 1'b0;
            locked_q    <= 1'b0;
            tries_q     <= TRIES_MAX;
        end else begin
            state_q     <= state_d;
            pin_q       <= pin_d;
            cnt_q       <= cnt_d;
            fail_q      <= fail_d;
            tmr_q       <= tmr_d;
            submit_q    <= submit;
            bug_q       <= bug_d;
            waiting_q   <= waiting_d;
            correct_q   <= correct_d;
            incorrect_q <= incorrect_d;
            approved_q  <= approved_d;
            locked_q    <= locked_d;
            tries_q     <= tries_d;
        end
    end

    assign waiting     = waiting_q;
    assign correct     = correct_q;
    assign incorrect   = incorrect_q;
    assign approved    = approved_q;
    assign locked      = locked_q;
    assign digit_count = cnt_q;
    assign tries_left  = tries_q;
    assign bug         = bug_q;

endmodule

// File: tb/tb_pin_check_multi.sv
// Bench for pin_check_multi: vector table, directed corner sequences and random entries
// checked every cycle against a queue-based reference model.
module tb_pin_check_multi;

    localparam int         PL  = 4;
    localparam int         MT  = 3;
    localparam int         HC  = 8;
    localparam int         LC  = 16;
    localparam logic [7:0] KEY = 8'hA5;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       submit  = 1'b0;
    logic       clear   = 1'b0;
    logic [1:0] digit   = 2'd0;
    logic       waiting, correct, incorrect, approved, locked, bug;
    logic [2:0] digit_count;
    logic [1:0] tries_left;

    int errors = 0;
    int checks = 0;
    int n_cor, n_inc, n_lck, n_apr;

    // Reference model state: digits typed so far, pending verdict, remaining display time.
    int m_digits[$];
    bit m_prev;
    int m_fails;
    int m_busy;
    int m_kind;   // 0 none, 1 ok, 2 bad, 3 lockout
    bit m_pend;
    bit m_apr;

    typedef struct {
        bit         sub;
        bit         clr;
        logic [1:0] dig;
        logic [10:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pin_check_multi #(
        .DIGIT_W(2), .PIN_LEN(PL), .PASSKEY(KEY), .MAX_TRIES(MT),
        .HOLD_CYCLES(HC), .LOCK_CYCLES(LC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .digit(digit), .submit(submit), .clear(clear),
        .waiting(waiting), .correct(correct), .incorrect(incorrect), .approved(approved),
        .locked(locked), .digit_count(digit_count), .tries_left(tries_left), .bug(bug)
    );

    function automatic logic [10:0] pack(input logic w, c, i, a, l,
                                         input logic [2:0] cnt, input logic [1:0] t,
                                         input logic b);
        return {w, c, i, a, l, cnt, t, b};
    endfunction

    localparam logic [10:0] RST_VEC = {5'b10000, 3'd0, 2'd3, 1'b0};

    function automatic logic [10:0] dut_vec();
        return pack(waiting, correct, incorrect, approved, locked, digit_count, tries_left, bug);
    endfunction

    function automatic logic [10:0] model_vec();
        return pack(!m_pend && m_busy == 0, m_kind == 1 && m_busy > 0, m_kind >= 2 && m_busy > 0,
                    m_apr, m_kind == 3 && m_busy > 0, 3'(m_digits.size()), 2'(MT - m_fails), 1'b0);
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_digits.delete();
        m_prev  = 1'b0;
        m_fails = 0;
        m_busy  = 0;
        m_kind  = 0;
        m_pend  = 1'b0;
        m_apr   = 1'b0;
    endtask

    task automatic model_step(input bit sub, input bit clr, input logic [1:0] dig);
        bit rise;
        int v;
        rise   = sub && !m_prev;
        m_prev = sub;
        m_apr  = 1'b0;
        if (m_pend) begin
            v = 0;
            foreach (m_digits[k]) v = v * 4 + m_digits[k];
            m_pend = 1'b0;
            if (v == int'(KEY)) begin
                m_fails = 0; m_kind = 1; m_busy = HC; m_apr = 1'b1;
            end else if (m_fails + 1 == MT) begin
                m_fails = MT; m_kind = 3; m_busy = LC;
            end else begin
                m_fails++; m_kind = 2; m_busy = HC;
            end
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_digits.delete();
                if (m_kind == 3) m_fails = 0;
                m_kind = 0;
            end
        end else if (clr) begin
            m_digits.delete();
        end else if (rise) begin
            m_digits.push_back(int'(dig));
            if (m_digits.size() == PL) m_pend = 1'b1;
        end
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge, compare after.
    task automatic tick(input bit sub, input bit clr, input logic [1:0] dig);
        submit = sub;
        clear  = clr;
        digit  = dig;
        @(posedge clk);
        model_step(sub, clr, dig);
        @(negedge clk);
        check("model", dut_vec(), model_vec());
        if (correct)   n_cor++;
        if (incorrect) n_inc++;
        if (locked)    n_lck++;
        if (approved)  n_apr++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 2'd0);
    endtask

    task automatic enter_pin(input logic [7:0] p);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, p[7-2*k -: 2]);
            tick(1'b0, 1'b0, 2'd0);
        end
    endtask

    task automatic zero_counts();
        n_cor = 0; n_inc = 0; n_lck = 0; n_apr = 0;
    endtask

    task automatic async_reset(input string name);
        #2;
        submit  = 1'b0;
        clear   = 1'b0;
        reset_n = 1'b0;
        #1;
        check(name, dut_vec(), RST_VEC);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input bit s, input bit c, input logic [1:0] d,
                                input logic w, cr, ap, input logic [2:0] cnt);
        vec_t v;
        v.sub = s; v.clr = c; v.dig = d;
        v.exp = pack(w, cr, 1'b0, ap, 1'b0, cnt, 2'd3, 1'b0);
        return v;
    endfunction

    initial begin
        logic [7:0] key_v;
        logic [1:0] d;
        bit         s, c;
        key_v = KEY;
        zero_counts();
        model_reset();

        repeat (2) @(negedge clk);
        check("reset", dut_vec(), RST_VEC);
        reset_n = 1'b1;

        // Correct PIN 2,2,1,1 followed by a clear racing a submit edge.
        vecs.push_back(mk(1, 0, 2'd2, 1, 0, 0, 3'd1));
        vecs.push_back(mk(0, 0, 2'd0, 1, 0, 0, 3'd1));
        vecs.push_back(mk(1, 0, 2'd2, 1, 0, 0, 3'd2));
        vecs.push_back(mk(0, 0, 2'd0, 1, 0, 0, 3'd2));
        vecs.push_back(mk(1, 0, 2'd1, 1, 0, 0, 3'd3));
        vecs.push_back(mk(0, 0, 2'd0, 1, 0, 0, 3'd3));
        vecs.push_back(mk(1, 0, 2'd1, 0, 0, 0, 3'd4));
        vecs.push_back(mk(0, 0, 2'd0, 0, 1, 1, 3'd4));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 2'd0, 0, 1, 0, 3'd4));
        vecs.push_back(mk(0, 0, 2'd0, 1, 0, 0, 3'd0));
        vecs.push_back(mk(1, 0, 2'd2, 1, 0, 0, 3'd1));
        vecs.push_back(mk(0, 0, 2'd0, 1, 0, 0, 3'd1));
        vecs.push_back(mk(1, 0, 2'd2, 1, 0, 0, 3'd2));
        vecs.push_back(mk(0, 0, 2'd0, 1, 0, 0, 3'd2));
        vecs.push_back(mk(1, 1, 2'd1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(1, 0, 2'd1, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 0, 0, 3'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].sub, vecs[i].clr, vecs[i].dig);
            check($sformatf("vec[%0d]", i), dut_vec(), vecs[i].exp);
        end
        check("ok_hold_len", 11'(n_cor), 11'd8);
        check("approved_len", 11'(n_apr), 11'd1);

        // Two wrong PINs.
        zero_counts();
        enter_pin(8'hFF);
        idle(10);
        check("bad_hold_len", 11'(n_inc), 11'd8);
        check("tries_after_1", 11'(tries_left), 11'd2);
        enter_pin(8'hFF);
        idle(10);
        check("tries_after_2", 11'(tries_left), 11'd1);
        check("no_lock_yet", 11'(n_lck), 11'd0);

        // Third wrong PIN: lockout with submit hammered throughout.
        zero_counts();
        enter_pin(8'hFF);
        for (int i = 0; i < 15; i++) tick(i % 2 == 0, 1'b0, 2'd2);
        idle(3);
        check("lock_len", 11'(n_lck), 11'd16);
        check("lock_incorrect_len", 11'(n_inc), 11'd16);
        check("lock_tries_after", 11'(tries_left), 11'd3);
        check("lock_count_after", 11'(digit_count), 11'd0);
        zero_counts();
        enter_pin(KEY);
        idle(10);
        check("ok_after_lock", 11'(n_cor), 11'd8);

        // Held submit, then a partial entry aborted by clear.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 2'd1);
        check("held_submit_count", 11'(digit_count), 11'd1);
        tick(1'b0, 1'b0, 2'd0);
        tick(1'b1, 1'b0, 2'd0);
        tick(1'b0, 1'b0, 2'd0);
        check("two_digits", 11'(digit_count), 11'd2);
        tick(1'b0, 1'b1, 2'd0);
        check("clear_count", 11'(digit_count), 11'd0);
        zero_counts();
        enter_pin(KEY);
        idle(10);
        check("ok_after_clear", 11'(n_apr), 11'd1);

        // Wrong, correct, wrong: the success resets the failure streak.
        zero_counts();
        enter_pin(8'h00);
        idle(10);
        enter_pin(KEY);
        idle(10);
        enter_pin(8'h5A);
        idle(10);
        check("streak_tries", 11'(tries_left), 11'd2);
        check("streak_no_lock", 11'(n_lck), 11'd0);

        // Asynchronous reset mid-entry, mid-hold, mid-lockout.
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, 2'd3);
            tick(1'b0, 1'b0, 2'd0);
        end
        check("pre_reset_count", 11'(digit_count), 11'd3);
        async_reset("reset_mid_entry");
        enter_pin(8'hFF);
        idle(3);
        check("pre_reset_hold", 11'(incorrect), 11'd1);
        async_reset("reset_mid_hold");
        for (int k = 0; k < 2; k++) begin
            enter_pin(8'hFF);
            idle(10);
        end
        enter_pin(8'hFF);
        idle(3);
        check("pre_reset_lock", 11'(locked), 11'd1);
        async_reset("reset_mid_lock");

        // Random entries, half the digits steered toward the key so some PINs match.
        for (int n = 0; n < 3000; n++) begin
            s = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1 && m_digits.size() < 4)
                d = key_v[7-2*m_digits.size() -: 2];
            else
                d = 2'($urandom_range(0, 3));
            tick(s, c, d);
        end

        check("bug_final", 11'(bug), 11'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
